// File: rtl/tilt_move_pulser.sv
// Turns debounced buttons and signed accelerometer tilt into one-cycle movement
// pulses {right,left,down,up}. A larger tilt gives a faster pulse rate.
module tilt_move_pulser #(
  parameter int CLK_HZ      = 100000000,
  parameter int BTN_RATE_HZ = 90,
  parameter int MAX_RATE_HZ = 120,
  parameter int ACC_W       = 9,
  parameter int DEADZONE    = 16,
  parameter int LVL_SHIFT   = 5,
  parameter int NUM_LEVELS  = 4,
  localparam int LW = $clog2(NUM_LEVELS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       btn_dir,
  input  logic [ACC_W-1:0] accel_x,
  input  logic [ACC_W-1:0] accel_y,
  input  logic             accel_valid,
  output logic [3:0]       move_pulses,
  output logic [LW-1:0]    level_x,
  output logic [LW-1:0]    level_y,
  output logic             active
);

  localparam int BTN_PERIOD  = CLK_HZ / BTN_RATE_HZ;
  localparam int BASE_PERIOD = CLK_HZ / MAX_RATE_HZ;
  localparam int AX_MAX      = BASE_PERIOD << (NUM_LEVELS - 1);
  localparam int AXW         = (AX_MAX > 1) ? $clog2(AX_MAX) : 1;
  localparam int BTW         = (BTN_PERIOD > 1) ? $clog2(BTN_PERIOD) : 1;
  localparam logic [ACC_W:0] DZ_W     = (ACC_W + 1)'(DEADZONE);
  localparam logic [ACC_W:0] TOP_STEP = (ACC_W + 1)'(NUM_LEVELS - 1);
  localparam logic [BTW-1:0] BTN_LAST = BTW'(BTN_PERIOD - 1);

  // Magnitude is one bit wider so the most negative sample maps to 2^(ACC_W-1).
  function automatic logic [LW-1:0] tilt_level(input logic signed [ACC_W-1:0] s);
    logic [ACC_W:0] mag;
    logic [ACC_W:0] steps;
    mag = s[ACC_W-1] ? ({1'b0, ~s} + (ACC_W + 1)'(1)) : {1'b0, s};
    if (mag <= DZ_W) return '0;
    steps = (mag - DZ_W) >> LVL_SHIFT;
    if (steps >= TOP_STEP) return LW'(NUM_LEVELS);
    return LW'(steps) + LW'(1);
  endfunction

  function automatic logic [AXW-1:0] period_m1(input logic [LW-1:0] lvl);
    int sh;
    sh = NUM_LEVELS - int'(lvl);
    if (sh < 0) sh = 0;
    return AXW'((BASE_PERIOD << sh) - 1);
  endfunction

  logic signed [ACC_W-1:0] smp_q [2];
  logic signed [ACC_W-1:0] smp_d [2];
  logic [LW-1:0]           lvl_q [2];
  logic [LW-1:0]           lvl_d [2];
  logic [AXW-1:0]          cnt_q [2];
  logic [AXW-1:0]          cnt_d [2];
  logic [1:0]              neg_q, neg_d;
  logic [1:0]              restart, tc;
  logic [BTW-1:0]          btn_cnt_q, btn_cnt_d;
  logic [3:0]              mp_q, mp_d;
  logic                    act_q, act_d;
  logic                    hold_axis, btn_tick;
  logic [3:0]              btn_eff, btn_p, ax_p, merged;

  always_comb begin
    smp_d = smp_q;
    if (accel_valid) begin
      smp_d[0] = $signed(accel_x);
      smp_d[1] = $signed(accel_y);
    end
    hold_axis = !enable || (mode == 2'b11 && |btn_dir);
    neg_d     = '0;
    restart   = '0;
    tc        = '0;
    for (int i = 0; i < 2; i++) begin
      lvl_d[i]   = tilt_level(smp_q[i]);
      neg_d[i]   = smp_q[i][ACC_W-1];
      restart[i] = (lvl_d[i] != lvl_q[i]) || (neg_d[i] != neg_q[i]);
      // A level or sign change cancels the pending terminal count.
      tc[i] = (lvl_q[i] != '0) && !restart[i] && (cnt_q[i] == period_m1(lvl_q[i]));
      if (hold_axis || lvl_q[i] == '0 || restart[i] || tc[i]) cnt_d[i] = '0;
      else                                                   cnt_d[i] = cnt_q[i] + AXW'(1);
    end
  end

  always_comb begin
    btn_tick  = enable && (btn_cnt_q == BTN_LAST);
    btn_cnt_d = (!enable || btn_tick) ? '0 : btn_cnt_q + BTW'(1);
    btn_eff   = btn_dir;
    if (btn_dir[3] && btn_dir[2]) btn_eff[3:2] = 2'b00;
    if (btn_dir[1] && btn_dir[0]) btn_eff[1:0] = 2'b00;
    btn_p = btn_tick ? btn_eff : 4'b0000;
    ax_p  = {tc[0] && !neg_q[0], tc[0] && neg_q[0], tc[1] && !neg_q[1], tc[1] && neg_q[1]};
    case (mode)
      2'b00:   merged = btn_p;
      2'b01:   merged = ax_p;
      2'b10:   merged = btn_p | ax_p;
      default: merged = (|btn_dir) ? btn_p : ax_p;
    endcase
    mp_d  = enable ? merged : 4'b0000;
    act_d = (|btn_dir) || (lvl_q[0] != '0) || (lvl_q[1] != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        smp_q[i] <= '0;
        lvl_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      neg_q     <= '0;
      btn_cnt_q <= '0;
      mp_q      <= '0;
      act_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        smp_q[i] <= smp_d[i];
        lvl_q[i] <= lvl_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      neg_q     <= neg_d;
      btn_cnt_q <= btn_cnt_d;
      mp_q      <= mp_d;
      act_q     <= act_d;
    end
  end

  assign move_pulses = mp_q;
  assign level_x     = lvl_q[0];
  assign level_y     = lvl_q[1];
  assign active      = act_q;

endmodule

// File: tb/tb_tilt_move_pulser.sv
// Bench for tilt_move_pulser: tilt-level table, directed multi-cycle sequences and
// randomized traffic compared every cycle against a rate-based reference model.
module tb_tilt_move_pulser;

  localparam int CLK_HZ = 1000, BTN_HZ = 100, MAX_HZ = 125;
  localparam int DZ = 16, LS = 5, NL = 4;
  localparam int BTN = CLK_HZ / BTN_HZ;
  localparam int BASE = CLK_HZ / MAX_HZ;

  logic              clk = 1'b0;
  logic              reset, enable, accel_valid;
  logic [1:0]        mode;
  logic [3:0]        btn_dir;
  logic signed [8:0] accel_x, accel_y;
  logic [3:0]        move_pulses;
  logic [2:0]        level_x, level_y;
  logic              active;

  tilt_move_pulser #(
    .CLK_HZ(CLK_HZ), .BTN_RATE_HZ(BTN_HZ), .MAX_RATE_HZ(MAX_HZ), .ACC_W(9),
    .DEADZONE(DZ), .LVL_SHIFT(LS), .NUM_LEVELS(NL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .btn_dir(btn_dir),
    .accel_x(accel_x), .accel_y(accel_y), .accel_valid(accel_valid),
    .move_pulses(move_pulses), .level_x(level_x), .level_y(level_y), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: sample -> level by formula, pulse when elapsed cycles hit a period multiple.
  int         m_smp [2];
  int         m_lvl [2];
  int         m_neg [2];
  int         m_age [2];
  int         m_bt;
  logic [3:0] m_out;
  int         m_act;

  function automatic int lvl_of(input int v);
    int mag, st;
    mag = (v < 0) ? -v : v;
    if (mag <= DZ) return 0;
    st = (mag - DZ) / (1 << LS);
    return ((st < NL - 1) ? st : NL - 1) + 1;
  endfunction

  task automatic model_step();
    int         nl, nn, p;
    bit         chg, hold, btick;
    bit         fire [2];
    logic [3:0] be, bp, ap, mg;
    if (!reset) begin
      for (int a = 0; a < 2; a++) begin
        m_smp[a] = 0; m_lvl[a] = 0; m_neg[a] = 0; m_age[a] = 0;
      end
      m_bt = 0; m_out = 4'b0000; m_act = 0;
      return;
    end
    hold  = !enable || (mode == 2'd3 && btn_dir != 4'b0000);
    m_act = (btn_dir != 4'b0000 || m_lvl[0] != 0 || m_lvl[1] != 0) ? 1 : 0;
    for (int a = 0; a < 2; a++) begin
      nl  = lvl_of(m_smp[a]);
      nn  = (m_smp[a] < 0) ? 1 : 0;
      chg = (nl != m_lvl[a]) || (nn != m_neg[a]);
      fire[a] = 1'b0;
      if (m_lvl[a] != 0 && !chg) begin
        p = BASE * (1 << (NL - m_lvl[a]));
        fire[a] = (m_age[a] % p) == p - 1;
      end
      m_age[a] = (hold || m_lvl[a] == 0 || chg) ? 0 : m_age[a] + 1;
    end
    btick = enable && (m_bt % BTN == BTN - 1);
    m_bt  = enable ? m_bt + 1 : 0;
    be = btn_dir;
    if (be[3] && be[2]) be[3:2] = 2'b00;
    if (be[1] && be[0]) be[1:0] = 2'b00;
    bp = btick ? be : 4'b0000;
    ap = {fire[0] && m_neg[0] == 0, fire[0] && m_neg[0] == 1,
          fire[1] && m_neg[1] == 0, fire[1] && m_neg[1] == 1};
    case (mode)
      2'd0:    mg = bp;
      2'd1:    mg = ap;
      2'd2:    mg = bp | ap;
      default: mg = (btn_dir != 4'b0000) ? bp : ap;
    endcase
    m_out = enable ? mg : 4'b0000;
    for (int a = 0; a < 2; a++) begin
      m_lvl[a] = lvl_of(m_smp[a]);
      m_neg[a] = (m_smp[a] < 0) ? 1 : 0;
    end
    if (accel_valid) begin
      m_smp[0] = int'(accel_x);
      m_smp[1] = int'(accel_y);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model_pulses", int'(move_pulses), int'(m_out));
    check("model_level_x", int'(level_x), m_lvl[0]);
    check("model_level_y", int'(level_y), m_lvl[1]);
    check("model_active", int'(active), m_act);
  endtask

  task automatic strobe(input int x, input int y);
    accel_x = 9'(x);
    accel_y = 9'(y);
    accel_valid = 1'b1;
    cyc();
    accel_valid = 1'b0;
    cyc();
  endtask

  task automatic watch(input int ncyc, input int b, input int gap, output int hits, output int others);
    int last;
    last = -1; hits = 0; others = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      if (move_pulses[b]) begin
        hits++;
        if (last >= 0) check("pulse_gap", i - last, gap);
        last = i;
      end
      if ((move_pulses & ~(4'b0001 << b)) != 4'b0000) others++;
    end
  endtask

  task automatic wait_bit(input int b, input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!move_pulses[b] && n < budget);
    check("wait_pulse_seen", int'(move_pulses[b]), 1);
  endtask

  typedef struct {
    int val;
    int exp_lvl;
  } lvl_vec_t;

  lvl_vec_t vec [12];

  initial begin
    int h, o, n;
    vec[0]  = '{0, 0};     vec[1]  = '{16, 0};   vec[2]  = '{17, 1};
    vec[3]  = '{47, 1};    vec[4]  = '{48, 2};   vec[5]  = '{111, 3};
    vec[6]  = '{112, 4};   vec[7]  = '{255, 4};  vec[8]  = '{-256, 4};
    vec[9]  = '{-16, 0};   vec[10] = '{-17, 1};  vec[11] = '{-81, 3};

    reset = 1'b0; enable = 1'b1; mode = 2'b00; btn_dir = 4'b1000;
    accel_x = 9'sd100; accel_y = 9'sd100; accel_valid = 1'b1;
    repeat (3) cyc();
    check("reset_pulses", int'(move_pulses), 0);
    check("reset_level_x", int'(level_x), 0);
    check("reset_level_y", int'(level_y), 0);
    check("reset_active", int'(active), 0);
    accel_valid = 1'b0;
    reset = 1'b1;

    // Held right button: five pulses, ten cycles apart.
    watch(50, 3, 10, h, o);
    check("btn_right_hits", h, 5);
    check("btn_right_others", o, 0);

    btn_dir = 4'b0011;
    watch(40, 0, 10, h, o);
    check("btn_cancel_hits", h, 0);
    check("btn_cancel_others", o, 0);

    btn_dir = 4'b0000; mode = 2'b01;
    strobe(200, 0);
    check("x200_level", int'(level_x), 4);
    watch(40, 3, 8, h, o);
    check("x200_right_hits", h, 5);
    check("x200_others", o, 0);
    strobe(50, 0);
    check("x50_level", int'(level_x), 2);
    wait_bit(3, 40, n);
    check("x50_restart_latency", n, 32);

    strobe(-10, 0);
    check("xm10_level", int'(level_x), 0);
    watch(30, 2, 8, h, o);
    check("xm10_hits", h, 0);
    check("xm10_others", o, 0);
    strobe(-256, 0);
    check("xm256_level", int'(level_x), 4);
    watch(40, 2, 8, h, o);
    check("xm256_left_hits", h, 5);
    check("xm256_others", o, 0);

    // Single-cycle reset mid-count wipes the captured tilt.
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("midreset_level_x", int'(level_x), 0);
    check("midreset_pulses", int'(move_pulses), 0);
    check("midreset_active", int'(active), 0);
    watch(20, 2, 8, h, o);
    check("postreset_hits", h, 0);
    check("postreset_others", o, 0);
    check("postreset_level_x", int'(level_x), 0);

    // Button override: up only while held, down tilt resumes once released.
    mode = 2'b11; btn_dir = 4'b0001;
    strobe(0, 200);
    check("y200_level", int'(level_y), 4);
    watch(40, 0, 10, h, o);
    check("override_up_hits", h, 4);
    check("override_down_hits", o, 0);
    btn_dir = 4'b0000;
    wait_bit(1, 20, n);
    check("release_latency", n, 8);
    watch(32, 1, 8, h, o);
    check("release_down_hits", h, 4);
    check("release_others", o, 0);

    mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      strobe(vec[i].val, -vec[i].val);
      check("table_level_x", int'(level_x), vec[i].exp_lvl);
      check("table_level_y", int'(level_y), vec[i].exp_lvl);
    end

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) btn_dir = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      accel_valid = ($urandom_range(0, 29) == 0);
      accel_x = 9'($urandom_range(0, 511));
      accel_y = 9'($urandom_range(0, 511));
      reset = ($urandom_range(0, 399) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
